cam_capture_ctrl: RTL
=====================

Name: cam_capture_ctrl

Overview:
- Sequences OV7670 pixel capture into the dual-port frame buffer (write port, 17-bit address, 12-bit RGB444 data).
- Aligns to frame start, pairs RGB565 bytes into RGB444 words, decimates 2:1 horizontally and vertically, and generates a linear write address.
- Supports continuous and single-shot (snapshot) capture.
- Runs in the camera pixel-clock domain, between the camera pins and the buffer write port.

Parameters:
- H_ACTIVE, 640, camera pixels per line (two bytes per pixel).
- V_ACTIVE, 480, camera lines per frame.
- ADDR_W, 17, frame-buffer address width.

Ports:
- clk  in  1  camera pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- vsync  in  1  camera VSYNC; high during vertical blanking, frame starts on its falling edge.
- href  in  1  camera HREF; high while line bytes are valid.
- d  in  8  camera data byte.
- capture_en  in  1  level; continuous capture while high.
- snap  in  1  single-cycle request to capture exactly one frame.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  buffer write address.
- wr_data  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of each captured frame.
- line_count  out  9  output lines written in the last completed frame.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, line_count=0.
  - FSM in IDLE; all counters 0.
  - A reset asserted mid-frame aborts the frame; no further writes occur.
- Inputs vsync, href and d are sampled into a one-stage register. All decisions use the registered copies.
- State machine:
  - IDLE: enter ARM when capture_en=1, or on a snap pulse (latch single_shot=1 if capture_en=0).
  - ARM: wait for registered vsync=1.
  - SYNC: wait for registered vsync=0 (falling edge = frame start). On entry to CAPTURE: wr_addr=0, line/pixel/byte counters=0.
  - CAPTURE: on registered vsync rising, pulse frame_done and load line_count. Then:
    - if single_shot=1 or capture_en=0, go to IDLE and clear single_shot;
    - otherwise go to SYNC.
  - Entering via ARM guarantees the first captured frame is complete (never a mid-frame start).
- Byte pairing, while href=1 in CAPTURE:
  - byte_phase toggles each cycle.
  - Phase 0: hold b0=d.
  - Phase 1: pixel = {b0[7:4], b0[2:0], d[7], d[4:1]}.
  - On href falling, byte_phase=0; a dangling phase-0 byte is discarded.
- Decimation:
  - A pixel is written only if pix_cnt[0]=0, line_cnt[0]=0, pix_cnt<H_ACTIVE and line_cnt<V_ACTIVE.
  - pix_cnt increments per completed pixel and clears on href falling.
  - line_cnt increments on each href falling edge.
  - Pixels beyond H_ACTIVE and lines beyond V_ACTIVE are dropped silently.
- Write timing:
  - wr_en pulses for 1 cycle, the cycle after the phase-1 byte is registered. wr_data is valid in the same cycle.
  - wr_addr holds the address of the current write, then increments by 1 the cycle after. Output is linear 320x240; maximum address written is 76799.
  - wr_addr never wraps within a frame.
- line_count = number of decimated lines holding at least one write. Short frames, where vsync rises early, still pulse frame_done with the smaller line_count.
- Boundary conditions:
  - snap while busy: ignored.
  - capture_en falling mid-frame: the current frame completes, then IDLE.
  - snap and capture_en rising in the same cycle: continuous mode (single_shot=0).
  - href asserted while vsync=1: ignored, no writes.

Test Plan:
- Single snap:
  - Stimulus: frame of 480 lines x 640 pixels; pixel n byte0=0xF8, byte1=0x1F.
  - Required: exactly 76800 writes, addresses 0..76799, wr_data=0xF0F each.
  - Then one frame_done pulse, line_count=240, busy=0.
- Mid-frame arm:
  - Stimulus: snap asserted during line 100 of a frame.
  - Required: no writes until after the next vsync high-to-low transition; a full 76800 writes follow.
- Continuous mode:
  - Stimulus: capture_en=1 for 3 frames, deasserted during frame 3.
  - Required: 3 frame_done pulses, wr_addr restarts at 0 each frame, IDLE after frame 3.
- Oversize and odd lines:
  - Stimulus: lines of 700 pixels plus 1 trailing byte; 500 lines.
  - Required: still 320 writes per kept line; last address 76799; no write from the dangling byte.
- Short frame:
  - Stimulus: vsync rises after 101 lines.
  - Required: frame_done pulses with line_count=51; last write address 16319.
- Reset mid-capture:
  - Stimulus: reset asserted at line 200 for 1 cycle.
  - Required: wr_en=0 from the next cycle, busy=0, no frame_done pulse; a subsequent snap captures a full frame from address 0.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: OV7670 capture sequencer; pairs RGB565 bytes into RGB444 pixels,
// decimates 2:1 in both axes and writes them to a linear frame buffer.
module cam_capture_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   input  logic              capture_en,
   input  logic              snap,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic [8:0]        line_count
);
   localparam int PW = $clog2(H_ACTIVE + 1);
   localparam int LW = $clog2(V_ACTIVE + 1);
   localparam logic [PW-1:0] PMAX = PW'(H_ACTIVE);
   localparam logic [LW-1:0] LMAX = LW'(V_ACTIVE);

   typedef enum logic [1:0] {IDLE, ARM, SYNC, CAPTURE} state_t;

   state_t state;
   logic vsync_r, href_r, vsync_q, href_q;
   logic [7:0] d_r;
   logic [6:0] b0;
   logic byte_phase, single_shot, line_hit;
   logic [PW-1:0] pix_cnt;
   logic [LW-1:0] line_cnt;
   logic [8:0] lines_done;
   logic href_fall, vsync_rise, keep;

   assign href_fall  = href_q & ~href_r;
   assign vsync_rise = vsync_r & ~vsync_q;
   assign keep       = ~pix_cnt[0] & ~line_cnt[0] & (pix_cnt < PMAX) & (line_cnt < LMAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_r <= 1'b0;
         href_r  <= 1'b0;
         d_r     <= '0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
      end else begin
         vsync_r <= vsync;
         href_r  <= href;
         d_r     <= d;
         vsync_q <= vsync_r;
         href_q  <= href_r;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         line_count  <= '0;
         b0          <= '0;
         byte_phase  <= 1'b0;
         single_shot <= 1'b0;
         line_hit    <= 1'b0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         lines_done  <= '0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
         case (state)
            IDLE: if (capture_en || snap) begin
               state       <= ARM;
               busy        <= 1'b1;
               single_shot <= ~capture_en;
            end
            ARM: if (vsync_r) state <= SYNC;
            SYNC: if (!vsync_r) begin
               state      <= CAPTURE;
               wr_addr    <= '0;
               pix_cnt    <= '0;
               line_cnt   <= '0;
               byte_phase <= 1'b0;
               lines_done <= '0;
               line_hit   <= 1'b0;
            end
            CAPTURE: if (vsync_rise) begin
               frame_done <= 1'b1;
               line_count <= lines_done + 9'(line_hit);
               if (single_shot || !capture_en) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  single_shot <= 1'b0;
               end else begin
                  state <= SYNC;
               end
            end else if (href_r) begin
               byte_phase <= ~byte_phase;
               if (!byte_phase) begin
                  b0 <= {d_r[7:4], d_r[2:0]};
               end else begin
                  if (pix_cnt < PMAX) pix_cnt <= pix_cnt + PW'(1);
                  if (keep) begin
                     wr_en    <= 1'b1;
                     wr_data  <= {b0, d_r[7], d_r[4:1]};
                     line_hit <= 1'b1;
                  end
               end
            end else begin
               // a dangling phase-0 byte is dropped by resetting the phase here
               byte_phase <= 1'b0;
               if (href_fall) begin
                  pix_cnt  <= '0;
                  line_hit <= 1'b0;
                  if (line_cnt < LMAX) line_cnt <= line_cnt + LW'(1);
                  if (line_hit) lines_done <= lines_done + 9'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
